// File: rtl/down_counter_reload.sv
// Synchronous down-counter / interval timer with parallel load, optional
// auto-reload and a registered one-cycle terminal-count pulse.
module down_counter_reload #(
    parameter int N = 4
) (
    input  logic         CLK,
    input  logic         Reset_n,
    input  logic         Load,
    input  logic [N-1:0] Din,
    input  logic         Count_En,
    input  logic         Auto_Reload,
    input  logic         Stop,
    output logic [N-1:0] Q,
    output logic         TC,
    output logic         Busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [N-1:0] ONE  = N'(1);
    localparam logic [N-1:0] ZERO = '0;

    state_t       state_reg;
    state_t       state_next;
    logic [N-1:0] count_reg;
    logic [N-1:0] count_next;
    logic [N-1:0] reload_reg;
    logic [N-1:0] reload_next;
    logic         tc_reg;
    logic         tc_next;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg  <= IDLE;
            count_reg  <= ZERO;
            reload_reg <= ZERO;
            tc_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            reload_reg <= reload_next;
            tc_reg     <= tc_next;
        end
    end

    // Load beats Stop beats counting; a zero count is never decremented.
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        reload_next = reload_reg;
        tc_next     = 1'b0;

        if (Load) begin
            count_next  = Din;
            reload_next = Din;
            state_next  = (Din != ZERO) ? RUN : IDLE;
        end else if (Stop) begin
            state_next = IDLE;
        end else if (state_reg == RUN && Count_En) begin
            if (count_reg == ONE) begin
                tc_next = 1'b1;
                if (Auto_Reload) begin
                    count_next = reload_reg;
                end else begin
                    count_next = ZERO;
                    state_next = IDLE;
                end
            end else if (count_reg != ZERO) begin
                count_next = count_reg - ONE;
            end
        end
    end

    assign Q    = count_reg;
    assign TC   = tc_reg;
    assign Busy = (state_reg == RUN);

endmodule

// File: tb/tb_down_counter_reload.sv
// Directed scoreboard bench for down_counter_reload, covering N=4 and N=8.
module tb_down_counter_reload;

    logic       CLK = 1'b0;
    logic       Reset_n;

    logic       load4, ce4, ar4, stop4;
    logic [3:0] din4;
    logic [3:0] q4;
    logic       tc4, busy4;

    logic       load8, ce8, ar8, stop8;
    logic [7:0] din8;
    logic [7:0] q8;
    logic       tc8, busy8;

    typedef struct {
        int         sel;
        logic [7:0] q;
        logic       tc;
        logic       busy;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    down_counter_reload #(.N(4)) dut4 (
        .CLK(CLK), .Reset_n(Reset_n), .Load(load4), .Din(din4),
        .Count_En(ce4), .Auto_Reload(ar4), .Stop(stop4),
        .Q(q4), .TC(tc4), .Busy(busy4)
    );

    down_counter_reload #(.N(8)) dut8 (
        .CLK(CLK), .Reset_n(Reset_n), .Load(load8), .Din(din8),
        .Count_En(ce8), .Auto_Reload(ar8), .Stop(stop8),
        .Q(q8), .TC(tc8), .Busy(busy8)
    );

    task automatic pushExpect(input int sel, input logic [7:0] eq, input logic etc,
                              input logic eb, input string tag);
        exp_t e;
        e.sel  = sel;
        e.q    = eq;
        e.tc   = etc;
        e.busy = eb;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t       e;
        logic [7:0] oq;
        logic       otc, ob;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_empty got 0 entries need 1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.sel == 0) begin
                oq = {4'b0000, q4};
                otc = tc4;
                ob = busy4;
            end else begin
                oq = q8;
                otc = tc8;
                ob = busy8;
            end
            checks++;
            assert (oq === e.q) else begin
                errors++;
                $error("[TB] FAIL %s.Q got %0d need %0d", e.tag, oq, e.q);
            end
            checks++;
            assert (otc === e.tc) else begin
                errors++;
                $error("[TB] FAIL %s.TC got %b need %b", e.tag, otc, e.tc);
            end
            checks++;
            assert (ob === e.busy) else begin
                errors++;
                $error("[TB] FAIL %s.Busy got %b need %b", e.tag, ob, e.busy);
            end
        end
    endtask

    // Drive one edge's inputs on the falling edge, then check just after the rising edge.
    task automatic applyStimulus(input int sel, input logic ld, input logic [7:0] d,
                                 input logic en, input logic ar, input logic st,
                                 input logic [7:0] eq, input logic etc, input logic eb,
                                 input string tag);
        @(negedge CLK);
        load4 = 1'b0; ce4 = 1'b0; stop4 = 1'b0;
        load8 = 1'b0; ce8 = 1'b0; stop8 = 1'b0;
        if (sel == 0) begin
            load4 = ld; din4 = d[3:0]; ce4 = en; ar4 = ar; stop4 = st;
        end else begin
            load8 = ld; din8 = d; ce8 = en; ar8 = ar; stop8 = st;
        end
        pushExpect(sel, eq, etc, eb, tag);
        @(posedge CLK);
        #1;
        checkOutput();
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired got timeout need finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        Reset_n = 1'b0;
        load4 = 1'b0; ce4 = 1'b0; ar4 = 1'b0; stop4 = 1'b0; din4 = '0;
        load8 = 1'b0; ce8 = 1'b0; ar8 = 1'b0; stop8 = 1'b0; din8 = '0;
        #12;
        pushExpect(0, 8'd0, 1'b0, 1'b0, "rst4");
        checkOutput();
        pushExpect(1, 8'd0, 1'b0, 1'b0, "rst8");
        checkOutput();
        @(negedge CLK);
        Reset_n = 1'b1;

        // Asynchronous reset in the middle of a count
        applyStimulus(0, 1, 7, 0, 0, 0, 7, 0, 1, "ld7");
        applyStimulus(0, 0, 0, 1, 0, 0, 6, 0, 1, "cnt6");
        @(negedge CLK);
        #2;
        Reset_n = 1'b0;
        #1;
        pushExpect(0, 8'd0, 1'b0, 1'b0, "async_rst");
        checkOutput();
        @(negedge CLK);
        Reset_n = 1'b1;

        // One-shot countdown from 5
        applyStimulus(0, 1, 5, 1, 0, 0, 5, 0, 1, "ld5");
        for (int i = 4; i >= 1; i--)
            applyStimulus(0, 0, 0, 1, 0, 0, 8'(i), 0, 1, "os5");
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 1, 0, "os5_exp");
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, "os5_after");

        // Auto-reload period of 3
        applyStimulus(0, 1, 3, 1, 1, 0, 3, 0, 1, "ld3ar");
        for (int k = 1; k <= 9; k++)
            applyStimulus(0, 0, 0, 1, 1, 0, 8'(3 - (k % 3)), (k % 3) == 0, 1, "ar3");

        // Gated enable
        applyStimulus(0, 1, 4, 0, 0, 0, 4, 0, 1, "ld4");
        applyStimulus(0, 0, 0, 1, 0, 0, 3, 0, 1, "g_en1");
        applyStimulus(0, 0, 0, 0, 0, 0, 3, 0, 1, "g_dis1");
        applyStimulus(0, 0, 0, 1, 0, 0, 2, 0, 1, "g_en2");
        applyStimulus(0, 0, 0, 0, 0, 0, 2, 0, 1, "g_dis2");
        applyStimulus(0, 0, 0, 1, 0, 0, 1, 0, 1, "g_en3");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, "g_dis3");
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 1, 0, "g_en4");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, "g_dis4");

        // Collisions
        applyStimulus(0, 1, 2, 0, 0, 0, 2, 0, 1, "ld2");
        applyStimulus(0, 0, 0, 1, 0, 0, 1, 0, 1, "at1");
        applyStimulus(0, 1, 9, 1, 0, 0, 9, 0, 1, "ld_on_expiry");
        applyStimulus(0, 1, 7, 1, 0, 1, 7, 0, 1, "ld_with_stop");
        applyStimulus(0, 0, 0, 1, 0, 0, 6, 0, 1, "to6");
        applyStimulus(0, 0, 0, 1, 0, 1, 6, 0, 0, "stop6");
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0, 0, 1, 0, 0, 6, 0, 0, "idle_hold6");

        // Boundaries for N=4
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 0, "ld0");
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 0, "ld0_hold");
        applyStimulus(0, 1, 15, 0, 0, 0, 15, 0, 1, "ld15");
        for (int i = 1; i <= 15; i++)
            applyStimulus(0, 0, 0, 1, 0, 0, 8'(15 - i), i == 15, i != 15, "cnt15");
        applyStimulus(0, 1, 1, 0, 0, 0, 1, 0, 1, "ld1");
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 1, 0, "ld1_exp");

        // Full range for N=8
        applyStimulus(1, 1, 255, 0, 0, 0, 255, 0, 1, "ld255");
        for (int i = 1; i <= 255; i++)
            applyStimulus(1, 0, 0, 1, 0, 0, 8'(255 - i), i == 255, i != 255, "cnt255");
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0, "n8_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
